// File: rtl/pool_mul_share_arbiter.sv
// pool_mul_share_arbiter: round-robin front end for one shared, ce-gated
// 16x8 unsigned multiplier. A {valid, id} tag pipeline runs in lock-step with
// the multiplier so every product comes back with the id of its requester,
// in issue order, on a single result channel.
module pool_mul_share_arbiter #(
  parameter int NREQ    = 2,
  parameter int MUL_LAT = 3,
  parameter int IDW     = 2,
  parameter int DATA_W  = 16,
  parameter int COEF_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [DATA_W*NREQ-1:0]   req_a,
  input  logic [COEF_W*NREQ-1:0]   req_b,
  input  logic                     drain,
  output logic                     mul_ce,
  output logic [DATA_W-1:0]        mul_din0,
  output logic [COEF_W-1:0]        mul_din1,
  input  logic [DATA_W-1:0]        mul_dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [IDW-1:0]           out_id,
  output logic                     busy
);

  // Padded request vector so an IDW-bit index always addresses it exactly.
  localparam int NPAD = 1 << IDW;

  logic [NPAD-1:0] valid_pad;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  scan_idx;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic            adv;
  logic            issue_ok;

  // Tag pipeline: one {valid, id} per multiplier stage.
  logic [MUL_LAT-1:0] vld_p;
  logic [IDW-1:0]     id_p [MUL_LAT];

  assign valid_pad = NPAD'(req_valid);

  // A result held at the output with no taker freezes the whole pipe.
  assign adv      = ~(out_valid & ~out_ready);
  assign mul_ce   = adv | reset;
  assign issue_ok = adv & ~drain & ~reset;

  // Round-robin scan: first valid requester at or after the pointer wins.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = ptr;
    for (int j = 0; j < NREQ; j++) begin
      if (issue_ok && !gnt_any && valid_pad[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
      scan_idx = (scan_idx == IDW'(NREQ - 1)) ? '0 : scan_idx + IDW'(1);
    end
  end

  // Grant decode: one-hot ready and operand steering; zeros when idle.
  always_comb begin
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_any && (gnt_idx == IDW'(i))) begin
        req_ready[i] = 1'b1;
        mul_din0     = req_a[DATA_W*i +: DATA_W];
        mul_din1     = req_b[COEF_W*i +: COEF_W];
      end
    end
  end

  // Pointer moves past the winner; holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end
  end

  // --- stage boundary: tag valid bits shift with the multiplier stages ---
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
    end else if (adv) begin
      vld_p[0] <= gnt_any;
      for (int s = 1; s < MUL_LAT; s++) begin
        vld_p[s] <= vld_p[s-1];
      end
    end
  end

  // --- stage boundary: tag ids shift under the same enable, no reset needed ---
  always_ff @(posedge clk) begin
    if (mul_ce) begin
      id_p[0] <= gnt_idx;
      for (int s = 1; s < MUL_LAT; s++) begin
        id_p[s] <= id_p[s-1];
      end
    end
  end

  assign out_valid = vld_p[MUL_LAT-1];
  assign out_id    = id_p[MUL_LAT-1];
  assign out_data  = mul_dout;
  assign busy      = |vld_p;

endmodule

// File: tb/tb_pool_mul_share_arbiter.sv
// Testbench for pool_mul_share_arbiter: randomized and directed traffic from two
// requesters, a ce-gated 3-stage multiplier stub, a transaction-level reference
// model (round-robin pointer plus an in-flight list aged per enabled edge) and a
// scoreboard popped by an independent result monitor.
module tb_pool_mul_share_arbiter;
  localparam int NREQ    = 2;
  localparam int MUL_LAT = 3;
  localparam int IDW     = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [16*NREQ-1:0] req_a;
  logic [8*NREQ-1:0]  req_b;
  logic              drain;
  logic              mul_ce;
  logic [15:0]       mul_din0;
  logic [7:0]        mul_din1;
  logic [15:0]       mul_dout;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;
  logic [IDW-1:0]    out_id;
  logic              busy;

  int tests = 0;
  int fails = 0;

  pool_mul_share_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .drain(drain), .mul_ce(mul_ce),
    .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier stub: operand reg, product reg, output reg, all gated by ce.
  logic [15:0] m_a, m_p, m_o;
  logic [7:0]  m_b;
  always @(posedge clk) begin
    if (mul_ce) begin
      m_a <= mul_din0;
      m_b <= mul_din1;
      m_p <= m_a * {8'd0, m_b};
      m_o <= m_p;
    end
  end
  assign mul_dout = m_o;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-requester pending operations {a[15:0], b[7:0]}.
  logic [23:0] pend0[$];
  logic [23:0] pend1[$];
  bit hs0 = 1'b0, hs1 = 1'b0;
  bit gap_en = 1'b0;

  task automatic push(input int r, input int a, input int b);
    if (r == 0) pend0.push_back({16'(a), 8'(b)});
    else        pend1.push_back({16'(a), 8'(b)});
  endtask

  // Handshake sampling while inputs are stable.
  always @(negedge clk) begin
    hs0 = req_valid[0] && req_ready[0];
    hs1 = req_valid[1] && req_ready[1];
  end

  // Requester driver: retire accepted operations, present the next ones.
  always @(posedge clk) begin
    #1;
    if (hs0 && pend0.size() > 0) pend0.delete(0);
    if (hs1 && pend1.size() > 0) pend1.delete(0);
    req_valid[0] = (pend0.size() > 0) && (!gap_en || $urandom_range(3) != 0);
    req_valid[1] = (pend1.size() > 0) && (!gap_en || $urandom_range(3) != 0);
    req_a[15:0]  = (pend0.size() > 0) ? pend0[0][23:8] : 16'($urandom);
    req_b[7:0]   = (pend0.size() > 0) ? pend0[0][7:0]  : 8'($urandom);
    req_a[31:16] = (pend1.size() > 0) ? pend1[0][23:8] : 16'($urandom);
    req_b[15:8]  = (pend1.size() > 0) ? pend1[0][7:0]  : 8'($urandom);
  end

  typedef struct packed { logic [1:0] id; logic [15:0] data; logic [7:0] age; } fl_t;
  typedef struct packed { logic [1:0] id; logic [15:0] data; } exp_t;
  fl_t  fl[$];
  exp_t sb[$];
  int   ptr = 0;

  // Reference model: grants, ce, busy, output timing; pushes expected results.
  always @(negedge clk) begin : model
    bit exp_ov, exp_adv;
    int g, idx;
    logic [1:0]  exp_rdy;
    logic [15:0] ea, ed;
    logic [7:0]  eb;
    exp_ov  = (fl.size() > 0) && (fl[0].age == 8'(MUL_LAT));
    exp_adv = !(exp_ov && !out_ready);
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    check("mul_ce", {31'd0, mul_ce}, {31'd0, exp_adv || reset});
    check("busy", {31'd0, busy}, {31'd0, fl.size() != 0});
    g = -1;
    if (exp_adv && !drain && !reset) begin
      for (int j = 0; j < NREQ; j++) begin
        idx = (ptr + j) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? 2'(1 << g) : 2'd0;
    ea = (g >= 0) ? req_a[16*g +: 16] : 16'd0;
    eb = (g >= 0) ? req_b[8*g +: 8] : 8'd0;
    check("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
    check("mul_din0", {16'd0, mul_din0}, {16'd0, ea});
    check("mul_din1", {24'd0, mul_din1}, {24'd0, eb});
    if (reset) begin
      fl.delete();
      sb.delete();
      ptr = 0;
    end else if (exp_adv) begin
      if (exp_ov) fl.pop_front();
      foreach (fl[k]) fl[k].age = fl[k].age + 8'd1;
      if (g >= 0) begin
        ed = 16'((32'(ea) * 32'(eb)) % 65536);
        fl.push_back('{id: 2'(g), data: ed, age: 8'd1});
        sb.push_back('{id: 2'(g), data: ed});
        ptr = (g + 1) % NREQ;
      end
    end
  end

  // Result monitor: compares each presented result with the scoreboard head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("orphan_result", 32'd1, 32'd0);
      end else begin
        e = sb[0];
        check("out_data", {16'd0, out_data}, {16'd0, e.data});
        check("out_id", {30'd0, out_id}, {30'd0, e.id});
        if (out_ready) sb.pop_front();
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int waited;
    reset = 1'b1; out_ready = 1'b1; drain = 1'b0;
    cyc(3);
    reset = 1'b0;
    // Single request and truncation cases.
    push(0, 300, 200);
    cyc(8);
    push(1, 1000, 100);
    push(1, 65535, 255);
    cyc(10);
    // Both requesters streaming.
    for (int i = 1; i <= 8; i++) begin
      push(0, i, 2);
      push(1, i, 3);
    end
    cyc(24);
    // Back-pressure with work in flight.
    push(0, 11, 5); push(1, 12, 6); push(0, 13, 7);
    cyc(3);
    out_ready = 1'b0;
    cyc(5);
    out_ready = 1'b1;
    cyc(8);
    // Reset with operations in flight; pointer must restart at 0.
    push(0, 21, 9); push(1, 22, 9);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    push(1, 7, 7); push(0, 9, 9);
    cyc(10);
    // Drain with both requesters pending.
    push(0, 31, 3); push(1, 32, 3); push(0, 33, 3); push(1, 34, 3);
    cyc(2);
    drain = 1'b1;
    cyc(8);
    drain = 1'b0;
    cyc(10);
    // Randomized traffic.
    gap_en = 1'b1;
    repeat (400) begin
      out_ready = ($urandom_range(3) != 0);
      drain     = ($urandom_range(15) == 0);
      reset     = ($urandom_range(99) == 0);
      if (pend0.size() < 3 && $urandom_range(1) == 1) push(0, int'($urandom_range(65535)), int'($urandom_range(255)));
      if (pend1.size() < 3 && $urandom_range(1) == 1) push(1, int'($urandom_range(65535)), int'($urandom_range(255)));
      cyc(1);
    end
    gap_en = 1'b0; reset = 1'b0; drain = 1'b0; out_ready = 1'b1;
    waited = 0;
    while ((pend0.size() > 0 || pend1.size() > 0 || sb.size() > 0 || busy) && waited < 300) begin
      cyc(1);
      waited++;
    end
    check("final_drain_timeout", 32'(waited >= 300), 32'd0);
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
